// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: default widths, partition channel
// indices, MV width helper and the best-MV tracker state type.
package me_pkg;

    localparam int SAD_W_DEF    = 16;
    localparam int NUM_PART_DEF = 7;

    localparam int P4X8   = 0;
    localparam int P8X4   = 1;
    localparam int P8X8   = 2;
    localparam int P8X16  = 3;
    localparam int P16X8  = 4;
    localparam int P16X16 = 5;
    localparam int P32X32 = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // One sign bit on top of the bits needed for the larger window dimension
    function automatic int mv_width(input int w, input int h);
        return $clog2((w > h) ? w : h) + 1;
    endfunction

endpackage

// File: rtl/sad_min_channel.sv
// One partition channel: keeps the smallest SAD seen so far and the MV where
// it was found. Ties keep the earlier candidate.
module sad_min_channel
    import me_pkg::*;
#(
    parameter int SAD_W = SAD_W_DEF,
    parameter int MV_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_first,
    input  logic             valid,
    input  logic [SAD_W-1:0] sad,
    input  logic [MV_W-1:0]  mv_x,
    input  logic [MV_W-1:0]  mv_y,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mv_x,
    output logic [MV_W-1:0]  best_mv_y
);

    logic [SAD_W-1:0] r_best_sad;
    logic [MV_W-1:0]  r_best_mv_x;
    logic [MV_W-1:0]  r_best_mv_y;
    logic             w_take;

    assign w_take = valid && (load_first || (sad < r_best_sad));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_sad  <= '0;
            r_best_mv_x <= '0;
            r_best_mv_y <= '0;
        end else if (w_take) begin
            r_best_sad  <= sad;
            r_best_mv_x <= mv_x;
            r_best_mv_y <= mv_y;
        end
    end

    assign best_sad  = r_best_sad;
    assign best_mv_x = r_best_mv_x;
    assign best_mv_y = r_best_mv_y;

endmodule

// File: rtl/sad_best_mv_tracker.sv
// Walks a raster search window, feeding per-partition SADs into min trackers,
// with optional early exit when the TERM_CH SAD drops to the threshold.
module sad_best_mv_tracker
    import me_pkg::*;
#(
    parameter int  SEARCH_W = 16,
    parameter int  SEARCH_H = 16,
    parameter int  NUM_PART = NUM_PART_DEF,
    parameter int  SAD_W    = SAD_W_DEF,
    parameter int  TERM_CH  = NUM_PART - 1,
    localparam int MV_W     = mv_width(SEARCH_W, SEARCH_H),
    localparam int CW       = $clog2(SEARCH_W),
    localparam int RW       = $clog2(SEARCH_H)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     early_en,
    input  logic [SAD_W-1:0]         thresh,
    input  logic                     sad_valid,
    input  logic [NUM_PART*SAD_W-1:0] sad_bus,
    output logic [CW-1:0]            search_column_count,
    output logic [RW-1:0]            search_row_count,
    output logic                     busy,
    output logic                     done,
    output logic                     early_term,
    output logic [NUM_PART*SAD_W-1:0] best_sad,
    output logic [NUM_PART*MV_W-1:0] best_mv_x,
    output logic [NUM_PART*MV_W-1:0] best_mv_y
);

    state_t           r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             r_busy;
    logic             r_done;
    logic             r_early_term;
    logic             r_early_en;
    logic [SAD_W-1:0] r_thresh;

    logic             w_accept;
    logic             w_first;
    logic             w_last_col;
    logic             w_last;
    logic             w_hit;
    logic [SAD_W-1:0] w_term_sad;
    logic [MV_W-1:0]  w_mv_x;
    logic [MV_W-1:0]  w_mv_y;

    assign w_accept   = (r_state == SEARCH) && sad_valid;
    assign w_first    = w_accept && (r_col == '0) && (r_row == '0);
    assign w_last_col = (r_col == CW'(SEARCH_W - 1));
    assign w_last     = w_last_col && (r_row == RW'(SEARCH_H - 1));
    assign w_term_sad = sad_bus[TERM_CH*SAD_W +: SAD_W];
    // Threshold looks at the incoming SAD, not the stored best
    assign w_hit      = r_early_en && (w_term_sad <= r_thresh);
    assign w_mv_x     = MV_W'(r_col) - MV_W'(SEARCH_W / 2);
    assign w_mv_y     = MV_W'(r_row) - MV_W'(SEARCH_H / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_early_term <= 1'b0;
            r_early_en   <= 1'b0;
            r_thresh     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= SEARCH;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_busy       <= 1'b1;
                        r_early_term <= 1'b0;
                        r_early_en   <= early_en;
                        r_thresh     <= thresh;
                    end
                end
                SEARCH: begin
                    if (sad_valid) begin
                        if (w_last || w_hit) begin
                            r_state      <= DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_early_term <= w_hit;
                            r_col        <= '0;
                            r_row        <= '0;
                        end else if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_col   <= '0;
                    r_row   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PART; gi++) begin : g_ch
            sad_min_channel #(
                .SAD_W (SAD_W),
                .MV_W  (MV_W)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .load_first (w_first),
                .valid      (w_accept),
                .sad        (sad_bus[gi*SAD_W +: SAD_W]),
                .mv_x       (w_mv_x),
                .mv_y       (w_mv_y),
                .best_sad   (best_sad[gi*SAD_W +: SAD_W]),
                .best_mv_x  (best_mv_x[gi*MV_W +: MV_W]),
                .best_mv_y  (best_mv_y[gi*MV_W +: MV_W])
            );
        end
    endgenerate

    assign search_column_count = r_col;
    assign search_row_count    = r_row;
    assign busy                = r_busy;
    assign done                = r_done;
    assign early_term          = r_early_term;

endmodule

// File: tb/tb_sad_best_mv_tracker.sv
// Bench for sad_best_mv_tracker on a 4x4 window with two channels; a raster
// reference model predicts each search and a negedge monitor checks outputs.
module tb_sad_best_mv_tracker;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int NP  = 2;
    localparam int SW  = 16;
    localparam int MVW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              early_en = 1'b0;
    logic [SW-1:0]     thresh = '0;
    logic              sad_valid = 1'b0;
    logic [NP*SW-1:0]  sad_bus = '0;
    logic [1:0]        col_cnt;
    logic [1:0]        row_cnt;
    logic              busy;
    logic              done;
    logic              early_term;
    logic [NP*SW-1:0]  best_sad;
    logic [NP*MVW-1:0] best_mv_x;
    logic [NP*MVW-1:0] best_mv_y;

    sad_best_mv_tracker #(
        .SEARCH_W (W),
        .SEARCH_H (H),
        .NUM_PART (NP),
        .SAD_W    (SW),
        .TERM_CH  (1)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .early_en            (early_en),
        .thresh              (thresh),
        .sad_valid           (sad_valid),
        .sad_bus             (sad_bus),
        .search_column_count (col_cnt),
        .search_row_count    (row_cnt),
        .busy                (busy),
        .done                (done),
        .early_term          (early_term),
        .best_sad            (best_sad),
        .best_mv_x           (best_mv_x),
        .best_mv_y           (best_mv_y)
    );

    always #5 clk = ~clk;

    int cand [16][2];
    int checks = 0;
    int errors = 0;

    // Expected idle-time outputs and done timing
    logic [NP*SW-1:0]  e_sad = '0;
    logic [NP*MVW-1:0] e_mvx = '0;
    logic [NP*MVW-1:0] e_mvy = '0;
    logic              e_et = 1'b0;
    bit                exp_done = 1'b0;

    // Model results for the search being driven
    int                m_n;
    logic              m_et;
    logic [NP*SW-1:0]  m_sad;
    logic [NP*MVW-1:0] m_mvx;
    logic [NP*MVW-1:0] m_mvy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Raster scan, strict-less update, stop when channel 1 SAD <= thresh
    task automatic model(input bit early, input int thr);
        int best [2];
        int mx [2];
        int my [2];
        m_n  = 0;
        m_et = 1'b0;
        for (int i = 0; i < W*H; i++) begin
            m_n = i + 1;
            for (int k = 0; k < NP; k++) begin
                if (i == 0 || cand[i][k] < best[k]) begin
                    best[k] = cand[i][k];
                    mx[k]   = (i % W) - W/2;
                    my[k]   = (i / W) - H/2;
                end
            end
            if (early && cand[i][1] <= thr) begin
                m_et = 1'b1;
                break;
            end
        end
        for (int k = 0; k < NP; k++) begin
            m_sad[k*SW +: SW]   = best[k][SW-1:0];
            m_mvx[k*MVW +: MVW] = mx[k][MVW-1:0];
            m_mvy[k*MVW +: MVW] = my[k][MVW-1:0];
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
            if (done)
                chk("done_counters", {60'd0, col_cnt, row_cnt}, 64'd0);
            if (!busy) begin
                chk("best_sad", {32'd0, best_sad}, {32'd0, e_sad});
                chk("best_mv_x", {58'd0, best_mv_x}, {58'd0, e_mvx});
                chk("best_mv_y", {58'd0, best_mv_y}, {58'd0, e_mvy});
                chk("early_term", {63'd0, early_term}, {63'd0, e_et});
            end
        end
    end

    task automatic drive_cand(input int i);
        sad_valid = 1'b1;
        sad_bus   = {cand[i][1][SW-1:0], cand[i][0][SW-1:0]};
    endtask

    task automatic run_search(input bit early, input int thr, input int gap,
                              input bit start_mid, input bit start_last);
        model(early, thr);
        @(posedge clk); #1;
        start = 1'b1; early_en = early; thresh = thr[SW-1:0];
        @(posedge clk); #1;
        start = 1'b0; early_en = 1'b0; thresh = '0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        e_sad = m_sad; e_mvx = m_mvx; e_mvy = m_mvy; e_et = m_et;
        for (int i = 0; i < m_n; i++) begin
            for (int g = 0; g < gap; g++) begin
                sad_valid = 1'b0;
                start = start_mid && (i == 2) && (g == 0);
                @(negedge clk);
                chk("gap_col", {62'd0, col_cnt}, 64'(i % W));
                chk("gap_row", {62'd0, row_cnt}, 64'(i / W));
                @(posedge clk); #1;
                start = 1'b0;
            end
            drive_cand(i);
            start = start_last && (i == m_n - 1);
            @(negedge clk);
            chk("cand_col", {62'd0, col_cnt}, 64'(i % W));
            chk("cand_row", {62'd0, row_cnt}, 64'(i / W));
            @(posedge clk); #1;
            start = 1'b0;
        end
        // Stray valid with SAD 0 during DONE and the following idle cycle
        sad_valid = 1'b1;
        sad_bus   = '0;
        exp_done  = 1'b1;
        @(posedge clk); #1;
        exp_done  = 1'b0;
        @(negedge clk);
        chk("post_busy", {63'd0, busy}, 64'd0);
        chk("post_counters", {60'd0, col_cnt, row_cnt}, 64'd0);
        @(posedge clk); #1;
        sad_valid = 1'b0;
        $display("search n=%0d early=%0d thr=%0d gap=%0d et=%0d sad=%h mvx=%b mvy=%b",
                 m_n, early, thr, gap, m_et, best_sad, best_mv_x, best_mv_y);
    endtask

    task automatic fill(input int v0, input int v1);
        for (int i = 0; i < W*H; i++) begin
            cand[i][0] = v0;
            cand[i][1] = v1;
        end
    endtask

    initial begin
        #2;
        chk("reset_outputs", {busy, done, early_term, col_cnt, row_cnt, best_sad, best_mv_x, best_mv_y}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // sad_valid while idle is ignored
        for (int i = 0; i < 3; i++) begin
            sad_valid = 1'b1;
            sad_bus   = 32'h0001_0002;
            @(negedge clk);
            chk("idle_valid_counters", {60'd0, col_cnt, row_cnt}, 64'd0);
            chk("idle_valid_busy", {63'd0, busy}, 64'd0);
            @(posedge clk); #1;
        end
        sad_valid = 1'b0;

        // Full search, tie on channel 1
        fill(100, 50);
        cand[6][0] = 20;
        run_search(1'b0, 0, 0, 1'b0, 1'b0);
        chk("lit_full_sad", {32'd0, best_sad}, {32'd0, 16'd50, 16'd20});
        chk("lit_full_mvx", {58'd0, best_mv_x}, {58'd0, 3'b110, 3'b000});
        chk("lit_full_mvy", {58'd0, best_mv_y}, {58'd0, 3'b110, 3'b111});

        // Reset at candidate 5 of a search
        fill(7, 9);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cand(i);
            @(posedge clk); #1;
        end
        drive_cand(5);
        rst_n = 1'b0;
        e_sad = '0; e_mvx = '0; e_mvy = '0; e_et = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, early_term, col_cnt, row_cnt, best_sad, best_mv_x, best_mv_y}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sad_valid = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {63'd0, busy}, 64'd0);

        // Clean search after reset
        fill(100, 50);
        cand[6][0] = 20;
        run_search(1'b0, 0, 0, 1'b0, 1'b0);
        chk("lit_clean_sad", {32'd0, best_sad}, {32'd0, 16'd50, 16'd20});

        // Early termination at index 5 (col1,row1)
        fill(100, 50);
        cand[5][1] = 25;
        run_search(1'b1, 30, 0, 1'b0, 1'b0);
        chk("lit_et_sad", {32'd0, best_sad}, {32'd0, 16'd25, 16'd100});
        chk("lit_et_mvx", {58'd0, best_mv_x}, {58'd0, 3'b111, 3'b110});
        chk("lit_et_mvy", {58'd0, best_mv_y}, {58'd0, 3'b111, 3'b110});
        chk("lit_et_flag", {63'd0, early_term}, 64'd1);
        chk("lit_et_n", 64'(m_n), 64'd6);

        // Gapped valid plus start pulses while busy and with the last candidate
        fill(100, 50);
        cand[6][0] = 20;
        run_search(1'b0, 0, 2, 1'b1, 1'b1);
        chk("lit_gap_sad", {32'd0, best_sad}, {32'd0, 16'd50, 16'd20});
        chk("lit_gap_mvx", {58'd0, best_mv_x}, {58'd0, 3'b110, 3'b000});

        // Max SAD values
        fill(32'hFFFF, 32'hFFFF);
        cand[15][0] = 32'hFFFE;
        cand[15][1] = 32'hFFFE;
        run_search(1'b0, 0, 0, 1'b0, 1'b0);
        chk("lit_max_sad", {32'd0, best_sad}, {32'd0, 16'hFFFE, 16'hFFFE});
        chk("lit_max_mvx", {58'd0, best_mv_x}, {58'd0, 3'b001, 3'b001});
        chk("lit_max_mvy", {58'd0, best_mv_y}, {58'd0, 3'b001, 3'b001});

        // Randomised searches
        for (int r = 0; r < 12; r++) begin
            int gap;
            for (int i = 0; i < W*H; i++) begin
                cand[i][0] = int'($urandom_range(0, 63));
                cand[i][1] = int'($urandom_range(0, 63));
            end
            gap = int'($urandom_range(0, 2));
            run_search(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), gap,
                       (gap > 0) && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_best_mv_tracker.md
Name: sad_best_mv_tracker

Overview:
- Parametrised successor stage to the basic-layer SAD search: consumes one SAD vector per search candidate for NUM_PART partitions (e.g. 4x8 … 32x32) in parallel.
- Walks a SEARCH_W x SEARCH_H raster search window and tracks the minimum SAD and its motion vector per partition.
- Supports optional early termination on a threshold.
- Sits between the PE array's SAD tree and the ME result/packing logic.

Parameters:
SEARCH_W, 16, search window width in candidates (≥2)
SEARCH_H, 16, search window height in candidates (≥2)
NUM_PART, 7, number of partition SAD channels
SAD_W, 16, bits per SAD value
TERM_CH, NUM_PART-1, channel index checked for early termination
MV_W, $clog2(max(SEARCH_W,SEARCH_H))+1, signed MV component width (derived, localparam-style)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new search; sampled only when idle
early_en  in  1  enable early termination; latched at start
thresh  in  SAD_W  early-termination threshold; latched at start
sad_valid  in  1  sad_bus holds SADs for current candidate
sad_bus  in  NUM_PART*SAD_W  channel k at bits [k*SAD_W +: SAD_W]
search_column_count  out  $clog2(SEARCH_W)  column of next expected candidate
search_row_count  out  $clog2(SEARCH_H)  row of next expected candidate
busy  out  1  search in progress
done  out  1  one-cycle pulse, results final
early_term  out  1  last search ended by threshold; held until next start
best_sad  out  NUM_PART*SAD_W  per-channel minimum SAD
best_mv_x  out  NUM_PART*MV_W  signed, per channel
best_mv_y  out  NUM_PART*MV_W  signed, per channel

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM to IDLE; latched thresh/early_en cleared.
- FSM states:
  - IDLE: start=1 → SEARCH; counters←0; busy←1; early_term←0; latch thresh/early_en.
  - SEARCH: each sad_valid accepts one candidate at (col,row) = (search_column_count, search_row_count).
    - col increments; at SEARCH_W-1 it wraps to 0 and row increments.
  - SEARCH → DONE after accepting candidate (SEARCH_W-1, SEARCH_H-1), or on early-termination hit.
  - DONE (one cycle): done=1, busy=0, counters←0 → IDLE.
- MV mapping: mv_x = col − SEARCH_W/2; mv_y = row − SEARCH_H/2 (two's complement, MV_W bits).
- Update rule per channel, registered on the cycle after sad_valid:
  - First candidate (0,0) loads unconditionally.
  - After that, update only if new SAD < best (strict); ties keep the earlier raster candidate.
  - Comparison is unsigned, full SAD_W width, no saturation.
- best_* are stable and valid from the done cycle until the next accepted candidate of a new search; they are not cleared at start.
- Early termination (early_en=1):
  - Evaluated on the SAD of channel TERM_CH just accepted (not the stored best).
  - If that SAD ≤ thresh: the update still applies, then → DONE and early_term←1.
  - Remaining candidates are not consumed.
- sad_valid while IDLE/DONE: ignored, no state change.
- start while busy: ignored.
- start and last sad_valid in the same cycle: start ignored.
- Latency: done asserts exactly 1 cycle after the terminating sad_valid; best_* updated in that same cycle.
- Reset mid-search: immediate IDLE, all outputs 0, partial results discarded.

Decomposition:
- Shared package me_pkg: SAD_W default, partition index constants (P4X8…P32X32), NUM_PART default, MV-width function, FSM state typedef {IDLE, SEARCH, DONE}.
- Sub-module: sad_min_channel, instantiated NUM_PART times via generate.
  - Holds one best SAD/MV pair.
  - Inputs: load_first, valid, sad, mv_x, mv_y.

Test Plan:
- Params SEARCH_W=4, SEARCH_H=4, NUM_PART=2, SAD_W=16. Reset asserted mid-stream at candidate 5 → all outputs 0, busy=0; a following start runs a clean search.
- Full search: ch0 SAD = 100 everywhere except 20 at (col2,row1); ch1 = 50 constant → done one cycle after the 16th sad_valid; ch0 best 20, mv (0,−1); ch1 best 50, mv (−2,−2) (tie keeps first).
- Early term: early_en=1, thresh=30, TERM_CH=1, ch1 SAD=25 at candidate 6 (col1,row1) → done after the 7th accepted sad_valid? No: after the 6th (index 5); early_term=1; ch1 best 25, mv (−1,−1); counters back to 0.
- sad_valid gaps: valid pulsed every 3rd cycle → same results as the back-to-back case; counters advance only on valid.
- Protocol: sad_valid while idle and start while busy → ignored; counters unchanged; no extra done.
- Max SAD: all SADs 16'hFFFF except final candidate 16'hFFFE → best 16'hFFFE, mv (1,1); first candidate 16'hFFFF is still loaded.
